my_alu_exec: RTL

- Registered execute stage wrapped around the existing 16-bit ALU (my_alu). It sits between the instruction issue logic upstream and writeback/PC-update downstream.
- It accepts operands, the six ALU control bits, the three Hack jump bits and a destination tag via a valid/ready handshake.
- It computes the ALU result and zr/ng flags, and evaluates the jump condition.
- Results are presented through a 2-entry skid buffer, so full throughput holds under downstream backpressure.

---
 rtl/my_alu_exec.sv | 138 +++++++++++++
 1 files changed

// File: rtl/my_alu_exec.sv
// rtl/my_alu_exec.sv - registered execute stage around the Hack ALU with a 2-entry skid buffer
module my_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [5:0]  ctrl,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = ctrl[5] ? 16'h0000 : x;
        x_n   = ctrl[4] ? ~x_z : x_z;
        y_z   = ctrl[3] ? 16'h0000 : y;
        y_n   = ctrl[2] ? ~y_z : y_z;
        f_out = ctrl[1] ? (x_n + y_n) : (x_n & y_n);
        out   = ctrl[0] ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end
endmodule

module my_alu_exec #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [5:0]       in_ctrl,
    input  logic [2:0]       in_jmp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_zr,
    output logic             out_ng,
    output logic             out_take,
    output logic [TAG_W-1:0] out_tag
);
    localparam int ENTRY_W = 16 + 3 + TAG_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [15:0]        alu_out;
    logic               alu_zr, alu_ng, alu_take;
    logic [ENTRY_W-1:0] new_entry, main_q, skid_q;
    logic               accept, rel;
    logic               main_load_new, main_load_skid, skid_load;

    my_alu u_alu (
        .x    (in_a),
        .y    (in_b),
        .ctrl (in_ctrl),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    assign alu_take  = (in_jmp[2] & alu_ng) | (in_jmp[1] & alu_zr) |
                       (in_jmp[0] & ~alu_ng & ~alu_zr);
    assign new_entry = {alu_out, alu_zr, alu_ng, alu_take, in_tag};

    assign accept = in_valid & in_ready;
    assign rel    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !rel)      state_nxt = ST_TWO;
                else if (!accept && rel) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (rel) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs decode the state only, so in_ready never depends on out_ready.
    always_comb begin
        in_ready  = (state != ST_TWO);
        out_valid = (state == ST_ONE) || (state == ST_TWO);
    end

    always_comb begin
        main_load_new  = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: main_load_new = accept;
            ST_ONE: begin
                main_load_new = accept & rel;
                skid_load     = accept & ~rel;
            end
            ST_TWO:   main_load_skid = rel;
            default: ;
        endcase
    end

    // Data registers only move on a load, so idle entries keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load_new)
                main_q <= new_entry;
            else if (main_load_skid)
                main_q <= skid_q;
            if (skid_load)
                skid_q <= new_entry;
        end
    end

    assign out_data = main_q[ENTRY_W-1 -: 16];
    assign out_zr   = main_q[TAG_W+2];
    assign out_ng   = main_q[TAG_W+1];
    assign out_take = main_q[TAG_W];
    assign out_tag  = main_q[TAG_W-1:0];
endmodule
